// File: rtl/rdma_arm_query_arb.sv
// Round-robin arbiter for CQ/EQ arm queries onto the UAR arm-table ports.
// Fixed 3-cycle response latency, one query per port every other cycle.
module rdma_arm_query_arb #(
  parameter int N_REQ = 4,
  parameter int NUM_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0]       req_is_eq,
  input  logic [N_REQ*NUM_W-1:0] req_num,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       resp_valid,
  output logic [N_REQ-1:0]       resp_armed,
  output logic                   cq_ren,
  output logic [NUM_W-1:0]       cq_num,
  input  logic                   cq_dout_reg,
  output logic                   eq_ren,
  output logic [NUM_W-1:0]       eq_num,
  input  logic                   eq_dout_reg,
  output logic                   busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  typedef logic [IW-1:0] idx_t;

  // port index 0 is CQ, 1 is EQ
  idx_t             ptr  [2];
  logic             ren_q[2];
  logic [NUM_W-1:0] num_q[2];
  logic [2:0]       tv   [2];
  idx_t             ti   [2][3];
  logic             arm3 [2];

  logic [N_REQ-1:0] cand [2];
  logic [IW:0]      pick [2];
  logic [1:0]       hit;
  idx_t             sel  [2];
  logic [N_REQ-1:0] gnt  [2];
  logic [1:0]       dout;

  function automatic logic [IW:0] rr_pick(
    input logic [N_REQ-1:0] c,
    input idx_t             p
  );
    logic [IW:0] r;
    int          k;
    r = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      k = (int'(p) + j) % N_REQ;
      if (c[k]) r = {1'b1, idx_t'(k)};
    end
    return r;
  endfunction

  function automatic idx_t nxt_ptr(input idx_t s);
    return (s == idx_t'(N_REQ - 1)) ? '0 : s + idx_t'(1);
  endfunction

  function automatic logic [NUM_W-1:0] get_num(input idx_t s);
    return req_num[int'(s)*NUM_W +: NUM_W];
  endfunction

  assign cand[0] = req_valid & ~req_is_eq;
  assign cand[1] = req_valid & req_is_eq;
  assign dout    = {eq_dout_reg, cq_dout_reg};

  // a port that issued last cycle (ren_q) is blocked this cycle
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      pick[p] = rr_pick(cand[p], ptr[p]);
      sel[p]  = pick[p][IW-1:0];
      hit[p]  = pick[p][IW] & ~ren_q[p];
      gnt[p]  = '0;
      if (hit[p]) gnt[p][sel[p]] = 1'b1;
    end
  end

  assign req_ready = gnt[0] | gnt[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < 2; p++) begin
        ptr[p]   <= '0;
        ren_q[p] <= 1'b0;
        num_q[p] <= '0;
        tv[p]    <= '0;
        arm3[p]  <= 1'b0;
        for (int s = 0; s < 3; s++) ti[p][s] <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        ren_q[p] <= hit[p];
        if (hit[p]) begin
          ptr[p]   <= nxt_ptr(sel[p]);
          num_q[p] <= get_num(sel[p]);
        end
        tv[p]    <= {tv[p][1:0], hit[p]};
        ti[p][0] <= sel[p];
        ti[p][1] <= ti[p][0];
        ti[p][2] <= ti[p][1];
        if (tv[p][1]) arm3[p] <= dout[p];
      end
    end
  end

  always_comb begin
    resp_valid = '0;
    resp_armed = '0;
    for (int p = 0; p < 2; p++) begin
      if (tv[p][2]) begin
        resp_valid[ti[p][2]] = 1'b1;
        resp_armed[ti[p][2]] = resp_armed[ti[p][2]] | arm3[p];
      end
    end
  end

  assign cq_ren = ren_q[0];
  assign cq_num = num_q[0];
  assign eq_ren = ren_q[1];
  assign eq_num = num_q[1];
  assign busy   = (|tv[0]) | (|tv[1]);

endmodule

// File: tb/tb_rdma_arm_query_arb.sv
// Bench for rdma_arm_query_arb: vector table, directed corners,
// and randomized traffic against a cycle-level reference model.
module tb_rdma_arm_query_arb;
  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_is_eq = '0;
  logic [N*W-1:0] req_num = '0;
  logic [N-1:0]   req_ready, resp_valid, resp_armed;
  logic           cq_ren, eq_ren, busy;
  logic [W-1:0]   cq_num, eq_num;
  logic           cq_dout_reg = 1'b0;
  logic           eq_dout_reg = 1'b0;

  int checks = 0;
  int passes = 0;

  // UAR arm tables: armed when gen != used; the bench arms, the UAR consumes
  int cq_gen[16], cq_used[16], eq_gen[16], eq_used[16];

  int g_idx[$], g_cyc[$];
  int n_gcq, n_geq;

  always #5 clk = ~clk;

  rdma_arm_query_arb #(.N_REQ(N), .NUM_W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_is_eq(req_is_eq),
    .req_num(req_num), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_armed(resp_armed),
    .cq_ren(cq_ren), .cq_num(cq_num),
    .cq_dout_reg(cq_dout_reg),
    .eq_ren(eq_ren), .eq_num(eq_num),
    .eq_dout_reg(eq_dout_reg), .busy(busy)
  );

  always @(posedge clk) begin
    if (cq_ren) begin
      cq_dout_reg <= (cq_gen[cq_num[3:0]] != cq_used[cq_num[3:0]]);
      cq_used[cq_num[3:0]] <= cq_gen[cq_num[3:0]];
    end
    if (eq_ren) begin
      eq_dout_reg <= (eq_gen[eq_num[3:0]] != eq_used[eq_num[3:0]]);
      eq_used[eq_num[3:0]] <= eq_gen[eq_num[3:0]];
    end
  end

  function automatic bit is_armed(input int p, input int t);
    return p == 0 ? (cq_gen[t] != cq_used[t]) : (eq_gen[t] != eq_used[t]);
  endfunction

  task automatic arm(input int p, input int t);
    if (!is_armed(p, t)) begin
      if (p == 0) cq_gen[t]++;
      else eq_gen[t]++;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    req_valid = '0;
    req_is_eq = '0;
    req_num   = '0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_req(input int i, input bit e, input int num);
    req_valid[i]       = 1'b1;
    req_is_eq[i]       = e;
    req_num[i*W +: W]  = num;
  endtask

  task automatic single(input int i, input bit e, input int num,
                        input bit exp_arm, input string tag);
    nxt();
    req_valid = '0;
    set_req(i, e, num);
    smp();
    chk({tag, " ready"}, req_ready, 64'(1 << i));
    nxt();
    req_valid = '0;
    smp();
    chk({tag, " ren"}, {cq_ren, eq_ren}, e ? 2'b01 : 2'b10);
    chk({tag, " num"}, e ? eq_num : cq_num, num);
    nxt();
    smp();
    chk({tag, " early resp"}, resp_valid, 0);
    nxt();
    smp();
    chk({tag, " resp_valid"}, resp_valid, 64'(1 << i));
    chk({tag, " armed"}, resp_armed[i], exp_arm);
    nxt();
  endtask

  // requester traffic generators: 0 random, 1 all CQ held, 2 req0 CQ + req3 EQ
  task automatic new_req(input int mode, input int i,
                         output bit v, output bit e, output int nm);
    case (mode)
      0: begin
        v  = $urandom_range(0, 3) != 0;
        e  = $urandom_range(0, 1) == 1;
        nm = $urandom_range(0, 15);
      end
      1: begin v = 1'b1; e = 1'b0; nm = i; end
      default: begin
        v  = (i == 0) || (i == 3);
        e  = (i == 3);
        nm = i + 1;
      end
    endcase
  endtask

  task automatic run(input int ncyc, input int mode);
    int          ptr[2], lastg[2], g[2], k;
    logic [W-1:0] lastn[2];
    bit          refa[2][16];
    bit          v[N], e[N];
    int          nm[N];
    int          due_c[$], due_o[$];
    bit          due_a[$];
    logic [N-1:0] er, ev, ea;
    bit          eb;
    do_reset();
    g_idx.delete();
    g_cyc.delete();
    n_gcq = 0;
    n_geq = 0;
    for (int t = 0; t < 16; t++) begin
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(0, 1) == 1) arm(p, t);
        refa[p][t] = is_armed(p, t);
      end
    end
    ptr   = '{0, 0};
    lastg = '{-10, -10};
    lastn = '{'0, '0};
    for (int i = 0; i < N; i++) new_req(mode, i, v[i], e[i], nm[i]);
    for (int c = 0; c < ncyc; c++) begin
      nxt();
      for (int i = 0; i < N; i++) begin
        req_valid[i]      = v[i];
        req_is_eq[i]      = e[i];
        req_num[i*W +: W] = nm[i];
      end
      er = '0;
      for (int p = 0; p < 2; p++) begin
        g[p] = -1;
        if (lastg[p] != c - 1) begin
          for (int j = 0; j < N; j++) begin
            k = (ptr[p] + j) % N;
            if (g[p] < 0 && v[k] && int'(e[k]) == p) g[p] = k;
          end
        end
        if (g[p] >= 0) er[g[p]] = 1'b1;
      end
      ev = '0;
      ea = '0;
      eb = 1'b0;
      for (int q = 0; q < due_c.size(); q++) begin
        if (due_c[q] == c) begin
          ev[due_o[q]] = 1'b1;
          ea[due_o[q]] = due_a[q];
        end
        if (due_c[q] - 2 <= c && c <= due_c[q]) eb = 1'b1;
      end
      smp();
      chk("rnd ready", req_ready, er);
      chk("rnd cq_ren", cq_ren, lastg[0] == c - 1);
      chk("rnd eq_ren", eq_ren, lastg[1] == c - 1);
      chk("rnd cq_num", cq_num, lastn[0]);
      chk("rnd eq_num", eq_num, lastn[1]);
      chk("rnd resp_valid", resp_valid, ev);
      chk("rnd resp_armed", resp_armed & ev, ea);
      chk("rnd busy", busy, eb);
      for (int i = 0; i < N; i++) begin
        if (req_ready[i]) begin
          g_idx.push_back(i);
          g_cyc.push_back(c);
          if (req_is_eq[i]) n_geq++;
          else n_gcq++;
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (g[p] >= 0) begin
          ptr[p]   = (g[p] + 1) % N;
          lastg[p] = c;
          lastn[p] = nm[g[p]];
          due_c.push_back(c + 3);
          due_o.push_back(g[p]);
          due_a.push_back(refa[p][nm[g[p]]]);
          refa[p][nm[g[p]]] = 1'b0;
          v[g[p]] = 1'b0;
        end
      end
      for (int i = 0; i < N; i++)
        if (!v[i]) new_req(mode, i, v[i], e[i], nm[i]);
      while (due_c.size() > 0 && due_c[0] < c) begin
        void'(due_c.pop_front());
        void'(due_o.pop_front());
        void'(due_a.pop_front());
      end
    end
    req_valid = '0;
  endtask

  typedef struct {
    logic [N-1:0] v;
    logic [N-1:0] e;
    logic [N-1:0] rdy;
  } vec_t;

  vec_t vt[8];
  int   nr;
  bit   a0, a1;
  logic [N-1:0] lv, seen;

  initial begin
    // expected grants follow the RR pointers carried from vector to vector
    vt[0] = '{4'b0001, 4'b0000, 4'b0001};
    vt[1] = '{4'b0011, 4'b0000, 4'b0010};
    vt[2] = '{4'b0101, 4'b0100, 4'b0101};
    vt[3] = '{4'b1111, 4'b1010, 4'b1100};
    vt[4] = '{4'b0000, 4'b0000, 4'b0000};
    vt[5] = '{4'b1010, 4'b0000, 4'b1000};
    vt[6] = '{4'b0110, 4'b0110, 4'b0010};
    vt[7] = '{4'b1111, 4'b1111, 4'b0100};

    do_reset();
    smp();
    chk("reset outputs",
        {req_ready, resp_valid, resp_armed, cq_ren, cq_num, eq_ren, eq_num, busy}, 0);

    for (int t = 0; t < 8; t++) begin
      nxt();
      req_valid = vt[t].v;
      req_is_eq = vt[t].e;
      smp();
      chk($sformatf("vec%0d ready", t), req_ready, vt[t].rdy);
      nxt();
      req_valid = '0;
      repeat (3) nxt();
    end

    arm(0, 5);
    single(0, 1'b0, 5, 1'b1, "cq5 first");
    single(0, 1'b0, 5, 1'b0, "cq5 repeat");
    arm(1, 7);
    single(2, 1'b1, 7, 1'b1, "eq7 first");

    do_reset();
    nxt();
    set_req(1, 1'b0, 3);
    set_req(2, 1'b1, 4);
    smp();
    chk("dual ready", req_ready, 4'b0110);
    nxt();
    req_valid = '0;
    smp();
    chk("dual ren", {cq_ren, eq_ren}, 2'b11);
    nxt();
    nxt();
    smp();
    chk("dual resp", resp_valid, 4'b0110);

    do_reset();
    nxt();
    set_req(2, 1'b0, 3);
    smp();
    chk("prereset ready", req_ready, 4'b0100);
    nxt();
    req_valid = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("async reset outputs",
        {req_ready, resp_valid, resp_armed, cq_ren, cq_num, eq_ren, eq_num, busy}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    seen = '0;
    for (int c = 0; c < 6; c++) begin
      smp();
      seen |= resp_valid;
      nxt();
    end
    chk("no resp after reset", seen, 0);
    req_valid = '0;
    set_req(1, 1'b0, 1);
    set_req(3, 1'b0, 2);
    smp();
    chk("ptr after reset", req_ready, 4'b0010);
    nxt();
    req_valid = '0;
    repeat (4) nxt();

    arm(0, 9);
    nxt();
    set_req(0, 1'b0, 9);
    set_req(1, 1'b0, 9);
    nr = 0;
    a0 = 1'b0;
    a1 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      smp();
      if (resp_valid != 0) begin
        if (nr == 0) a0 = |(resp_armed & resp_valid);
        else a1 = |(resp_armed & resp_valid);
        nr++;
      end
      lv = req_valid & ~req_ready;
      nxt();
      req_valid = lv;
    end
    chk("cq9 resp count", nr, 2);
    chk("cq9 first armed", a0, 1'b1);
    chk("cq9 second armed", a1, 1'b0);

    run(12, 1);
    chk("allcq grants", g_idx.size() >= 4, 1'b1);
    if (g_idx.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("allcq idx%0d", i), g_idx[i], i);
        chk($sformatf("allcq cyc%0d", i), g_cyc[i], 2 * i);
      end
    end

    run(40, 2);
    chk("mixed cq grants", n_gcq, 20);
    chk("mixed eq grants", n_geq, 20);

    run(800, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
